// File: rtl/sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl
// Purpose  : Command sequencer from UART RX bytes to register file and ALU
//            strobes. Returns read data and ALU results on the UART TX path.
// Revision : 1.0 - initial release
// ============================================================================
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int OPA_ADDR   = 0,
    parameter int OPB_ADDR   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    TX_BUSY,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam logic [DATA_WIDTH-1:0] CMD_WRITE  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_READ   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OPA      = 4'd5,
        OPB      = 4'd6,
        FUN      = 4'd7,
        ALU_WAIT = 4'd8,
        TX_LO    = 4'd9,
        TX_HI    = 4'd10
    } state_t;

    state_t                    state, state_nx;
    logic [ADDR_WIDTH-1:0]     addr_hold, addr_hold_nx;
    logic [2*DATA_WIDTH-1:0]   result, result_nx;
    logic                      two_byte, two_byte_nx;
    logic                      wr_en_nx, rd_en_nx, alu_en_nx, clk_en_nx, tx_vld_nx;
    logic [ADDR_WIDTH-1:0]     address_nx;
    logic [DATA_WIDTH-1:0]     wr_data_nx, tx_data_nx;
    logic [FUN_WIDTH-1:0]      alu_fun_nx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            addr_hold <= '0;
            result    <= '0;
            two_byte  <= 1'b0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            ALU_EN    <= 1'b0;
            ALU_FUN   <= '0;
            CLK_EN    <= 1'b0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
        end else begin
            state     <= state_nx;
            addr_hold <= addr_hold_nx;
            result    <= result_nx;
            two_byte  <= two_byte_nx;
            WrEn      <= wr_en_nx;
            RdEn      <= rd_en_nx;
            Address   <= address_nx;
            WrData    <= wr_data_nx;
            ALU_EN    <= alu_en_nx;
            ALU_FUN   <= alu_fun_nx;
            CLK_EN    <= clk_en_nx;
            TX_P_DATA <= tx_data_nx;
            TX_D_VLD  <= tx_vld_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        addr_hold_nx = addr_hold;
        result_nx    = result;
        two_byte_nx  = two_byte;
        wr_en_nx     = 1'b0;
        rd_en_nx     = 1'b0;
        alu_en_nx    = 1'b0;
        address_nx   = Address;
        wr_data_nx   = WrData;
        alu_fun_nx   = ALU_FUN;
        tx_data_nx   = TX_P_DATA;
        tx_vld_nx    = TX_D_VLD;

        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WRITE:  state_nx = WR_ADDR;
                        CMD_READ:   state_nx = RD_ADDR;
                        CMD_ALU_OP: state_nx = OPA;
                        CMD_ALU_NO: state_nx = FUN;
                        default:    state_nx = IDLE;
                    endcase
                end
            end
            // Address is held privately so the Address port keeps its last strobe value
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_hold_nx = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nx     = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_nx   = 1'b1;
                    address_nx = addr_hold;
                    wr_data_nx = RX_P_DATA;
                    state_nx   = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_nx   = 1'b1;
                    address_nx = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nx   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RdData_Valid) begin
                    result_nx   = {{DATA_WIDTH{1'b0}}, RdData};
                    two_byte_nx = 1'b0;
                    state_nx    = TX_LO;
                end
            end
            OPA: begin
                if (RX_D_VLD) begin
                    wr_en_nx   = 1'b1;
                    address_nx = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_nx = RX_P_DATA;
                    state_nx   = OPB;
                end
            end
            OPB: begin
                if (RX_D_VLD) begin
                    wr_en_nx   = 1'b1;
                    address_nx = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_nx = RX_P_DATA;
                    state_nx   = FUN;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    alu_en_nx  = 1'b1;
                    alu_fun_nx = RX_P_DATA[FUN_WIDTH-1:0];
                    state_nx   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_nx   = ALU_OUT;
                    two_byte_nx = 1'b1;
                    state_nx    = TX_LO;
                end
            end
            // Request once the transmitter is free, release once it reports busy
            TX_LO, TX_HI: begin
                if (!TX_D_VLD) begin
                    if (!TX_BUSY) begin
                        tx_vld_nx  = 1'b1;
                        tx_data_nx = (state == TX_LO) ? result[DATA_WIDTH-1:0]
                                                      : result[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                end else if (TX_BUSY) begin
                    tx_vld_nx = 1'b0;
                    state_nx  = (state == TX_LO && two_byte) ? TX_HI : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        clk_en_nx = (state_nx == FUN) || (state_nx == ALU_WAIT);
    end

endmodule
`default_nettype wire
